// File: rtl/t03_imm_gen_pipe.sv
// rtl/t03_imm_gen_pipe.sv - elastic pipelined RISC-V immediate generator
module t03_imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       type_i,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_gen,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("t03_imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("t03_imm_gen_pipe: STAGES must be in 1..3");
  end

  logic            s;
  logic            unused_opcode;
  logic [XLEN-1:0] imm_form;

  assign s             = inst[31];
  assign unused_opcode = ^inst[6:0];

  always_comb begin
    imm_form = '0;
    case (type_i)
      3'd1:    imm_form = {{(XLEN-12){s}}, inst[31:20]};
      3'd2:    imm_form = {{(XLEN-12){s}}, inst[31:25], inst[11:7]};
      3'd3:    imm_form = {{(XLEN-13){s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd4:    imm_form = {{(XLEN-32){s}}, inst[31:12], 12'h000};
      3'd5:    imm_form = {{(XLEN-21){s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'd6:    imm_form = XLEN'(inst[19:15]);
      3'd7:    imm_form = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      default: imm_form = '0;
    endcase
  end

  logic [STAGES-1:0] valid_q, valid_d, adv;
  logic [XLEN-1:0]   imm_q [STAGES];
  logic [XLEN-1:0]   imm_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic              rdy_chain;

  // A stage may load if it is empty or everything downstream of it can move.
  always_comb begin
    rdy_chain = out_ready;
    adv       = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]    = !valid_q[k] || rdy_chain;
      rdy_chain = adv[k];
    end
  end

  // Data only moves with a valid entry, so outputs hold while idle or stalled.
  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    tag_d   = tag_q;
    if (adv[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        imm_d[0] = imm_form;
        tag_d[0] = in_tag;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          imm_d[k] = imm_q[k-1];
          tag_d[k] = tag_q[k-1];
        end
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        imm_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign imm_gen   = imm_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_t03_imm_gen_pipe.sv
// tb/tb_t03_imm_gen_pipe.sv - scoreboard bench for t03_imm_gen_pipe
module tb_t03_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_rst = 1'b0;

  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic [31:0] a_inst = 0;
  logic [2:0]  a_type = 0;
  logic [7:0]  a_in_tag = 0, a_out_tag;
  logic [31:0] a_imm;

  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic [31:0] b_inst = 0;
  logic [2:0]  b_type = 0;
  logic [7:0]  b_in_tag = 0, b_out_tag;
  logic [63:0] b_imm;

  t03_imm_gen_pipe #(.XLEN(32), .STAGES(3), .TAG_W(8)) dut_a (
    .clk(clk), .nRst(n_rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .inst(a_inst), .type_i(a_type), .in_tag(a_in_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .imm_gen(a_imm), .out_tag(a_out_tag));

  t03_imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(8)) dut_b (
    .clk(clk), .nRst(n_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .inst(b_inst), .type_i(b_type), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .imm_gen(b_imm), .out_tag(b_out_tag));

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t a_e, b_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] TV_INST [10] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7,
    32'hFFDFF06F, 32'h000FD073, 32'h01F0D093, 32'hDEADBEEF, 32'h800000B7, 32'h03F0D093};
  localparam logic [2:0] TV_TYPE [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd4, 3'd7};
  localparam logic [63:0] TV_E64 [10] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC,
    64'hFFFFFFFF_FFFFFFF8, 64'h00000000_12345000, 64'hFFFFFFFF_FFFFFFFC, 64'h1F, 64'h1F, 64'h0,
    64'hFFFFFFFF_80000000, 64'h3F};
  localparam logic [31:0] TV_E32 [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
    32'hFFFFFFFC, 32'h1F, 32'h1F, 32'h0, 32'h80000000, 32'h1F};

  // Reference: assemble the immediate's numeric value from its bit fields, then sign it.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] ty, input bit x64);
    longint unsigned u;
    longint          f;
    int              w;
    u = 64'(ins);
    f = 0;
    w = 0;
    case (ty)
      3'd1: begin f = longint'(u >> 20); w = 12; end
      3'd2: begin f = longint'(((u >> 25) << 5) + ((u >> 7) & 31)); w = 12; end
      3'd3: begin f = longint'(((u >> 31) << 12) + (((u >> 7) & 1) << 11) + (((u >> 25) & 63) << 5)
                             + (((u >> 8) & 15) << 1)); w = 13; end
      3'd4: begin f = longint'(u & 64'hFFFF_F000); w = 32; end
      3'd5: begin f = longint'(((u >> 31) << 20) + (((u >> 12) & 255) << 12) + (((u >> 20) & 1) << 11)
                             + (((u >> 21) & 1023) << 1)); w = 21; end
      3'd6: f = longint'((u >> 15) & 31);
      3'd7: f = longint'((u >> 20) & (x64 ? 64'd63 : 64'd31));
      default: f = 0;
    endcase
    if (w != 0 && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    return x64 ? 64'(f) : {32'd0, f[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue side: record accepted transfers, forget everything on flush or reset.
  always @(negedge clk) begin
    #1;
    if (!n_rst || a_flush) qa.delete();
    else if (a_in_valid && a_in_ready) begin
      a_e.imm = ref_imm(a_inst, a_type, 1'b0);
      a_e.tag = a_in_tag;
      qa.push_back(a_e);
    end
    if (!n_rst || b_flush) qb.delete();
    else if (b_in_valid && b_in_ready) begin
      b_e.imm = ref_imm(b_inst, b_type, 1'b1);
      b_e.tag = b_in_tag;
      qb.push_back(b_e);
    end
  end

  // Output side: every presented entry must match the oldest outstanding one.
  always @(negedge clk) begin
    if (a_out_valid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_output: got tag %0d imm %h, expected no output", a_out_tag, a_imm);
      end else begin
        check("a_sb_imm", 64'(a_imm), qa[0].imm);
        check("a_sb_tag", 64'(a_out_tag), 64'(qa[0].tag));
        if (a_out_ready) void'(qa.pop_front());
      end
    end
    if (b_out_valid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_output: got tag %0d imm %h, expected no output", b_out_tag, b_imm);
      end else begin
        check("b_sb_imm", b_imm, qb[0].imm);
        check("b_sb_tag", 64'(b_out_tag), 64'(qb[0].tag));
        if (b_out_ready) void'(qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    tick(); tick();
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_imm", 64'(a_imm), 64'd0);
    check("rst_a_out_tag", 64'(a_out_tag), 64'd0);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_imm", b_imm, 64'd0);
    n_rst = 1'b1;
    tick();
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);

    // 64-bit, single stage: each vector visible one cycle after its transfer
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1; b_inst = TV_INST[i]; b_type = TV_TYPE[i]; b_in_tag = 8'(i);
      tick();
      check("b_type_valid", 64'(b_out_valid), 64'd1);
      check("b_type_imm", b_imm, TV_E64[i]);
      check("b_type_tag", 64'(b_out_tag), 64'(i));
    end
    b_in_valid = 0;
    tick();
    check("b_idle_valid", 64'(b_out_valid), 64'd0);

    // 32-bit, three stages: same vectors, three-cycle latency
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        a_in_valid = 1; a_inst = TV_INST[i]; a_type = TV_TYPE[i]; a_in_tag = 8'(8'h40 + i);
      end else a_in_valid = 0;
      tick();
      if (i == 1) check("a_latency_early", 64'(a_out_valid), 64'd0);
      if (i >= 2) begin
        check("a_type_valid", 64'(a_out_valid), 64'd1);
        check("a_type_imm", 64'(a_imm), 64'(TV_E32[i-2]));
      end
    end
    tick();

    // Streaming: ten back-to-back I-type transfers
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        a_in_valid = 1; a_inst = {$urandom_range(0, 4095) & 32'hFFF, 20'h00093}; a_type = 3'd1;
        a_in_tag = 8'(i);
        #1;
        check("a_stream_in_ready", 64'(a_in_ready), 64'd1);
      end else a_in_valid = 0;
      @(posedge clk); #1;
      if (i >= 2) begin
        check("a_stream_valid", 64'(a_out_valid), 64'd1);
        check("a_stream_tag", 64'(a_out_tag), 64'(i - 2));
      end
    end
    tick();

    // Back-pressure: only three entries fit while the consumer stalls
    a_out_ready = 0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1; a_inst = $urandom; a_type = 3'd1; a_in_tag = 8'(acc);
      #1;
      if (a_in_ready) acc++;
      @(posedge clk); #1;
    end
    check("a_bp_accepted", 64'(acc), 64'd3);
    check("a_bp_in_ready", 64'(a_in_ready), 64'd0);
    check("a_bp_out_valid", 64'(a_out_valid), 64'd1);
    a_out_ready = 1;
    a_in_tag = 8'd3;
    #1;
    check("a_bp_release_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_tag = 8'd4; a_inst = $urandom;
    tick();
    a_in_valid = 0;
    for (int i = 0; i < 10 && qa.size() != 0; i++) tick();
    check("a_bp_drained", 64'(qa.size()), 64'd0);

    // Flush with two in flight plus a simultaneous transfer
    a_out_ready = 0;
    a_in_valid = 1; a_type = 3'd2; a_inst = $urandom; a_in_tag = 8'h20;
    tick();
    a_in_tag = 8'h21; a_inst = $urandom;
    tick();
    a_in_tag = 8'h22; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    check("a_flush_out_valid", 64'(a_out_valid), 64'd0);
    check("a_flush_in_ready", 64'(a_in_ready), 64'd1);
    repeat (4) tick();
    a_in_valid = 1; a_type = 3'd5; a_inst = $urandom; a_in_tag = 8'h23;
    tick();
    a_in_valid = 0;
    repeat (4) tick();

    // Randomised traffic on both instances
    fork
      for (int i = 0; i < 600; i++) begin
        a_in_valid = ($urandom_range(0, 9) < 7); a_out_ready = ($urandom_range(0, 9) < 6);
        a_flush = ($urandom_range(0, 39) == 0); a_inst = $urandom; a_type = 3'($urandom_range(0, 7));
        a_in_tag = 8'($urandom);
        tick();
      end
      for (int i = 0; i < 300; i++) begin
        b_in_valid = ($urandom_range(0, 9) < 7); b_out_ready = ($urandom_range(0, 9) < 6);
        b_flush = ($urandom_range(0, 49) == 0); b_inst = $urandom; b_type = 3'($urandom_range(0, 7));
        b_in_tag = 8'($urandom);
        tick();
      end
    join
    a_in_valid = 0; a_flush = 0; a_out_ready = 1;
    b_in_valid = 0; b_flush = 0; b_out_ready = 1;
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    check("rand_a_drained", 64'(qa.size()), 64'd0);
    check("rand_b_drained", 64'(qb.size()), 64'd0);

    // Asynchronous reset while full and stalled
    a_out_ready = 0;
    a_in_valid = 1; a_inst = 32'hFFF00093; a_type = 3'd1; a_in_tag = 8'hAA;
    repeat (4) tick();
    a_in_valid = 0;
    check("a_full_before_rst", 64'(a_out_valid), 64'd1);
    #1 n_rst = 0;
    #1;
    check("a_async_rst_valid", 64'(a_out_valid), 64'd0);
    check("a_async_rst_imm", 64'(a_imm), 64'd0);
    check("a_async_rst_tag", 64'(a_out_tag), 64'd0);
    tick(); tick();
    #1 n_rst = 1;
    tick();
    check("a_post_rst_in_ready", 64'(a_in_ready), 64'd1);
    a_out_ready = 1;
    a_in_valid = 1; a_inst = 32'h00500093; a_type = 3'd1; a_in_tag = 8'h55;
    tick();
    a_in_valid = 0;
    tick(); tick();
    check("a_post_rst_valid", 64'(a_out_valid), 64'd1);
    check("a_post_rst_imm", 64'(a_imm), 64'h5);
    check("a_post_rst_tag", 64'(a_out_tag), 64'h55);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
